// File: rtl/hyperbus_traffic_gen_if.sv
// AXI4 master/slave channel bundle between the traffic generator and the
// HyperBus controller slave port (burst type, size and ID are tied off
// downstream, so only the fields the generator drives or checks appear here).
interface hyperbus_traffic_gen_if #(
    parameter int AW = 32,
    parameter int DW = 16
);
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic            aw_valid;
    logic            aw_ready;

    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic            w_last;
    logic            w_valid;
    logic            w_ready;

    logic [1:0]      b_resp;
    logic            b_valid;
    logic            b_ready;

    logic [AW-1:0]   ar_addr;
    logic [7:0]      ar_len;
    logic            ar_valid;
    logic            ar_ready;

    logic [DW-1:0]   r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic            r_valid;
    logic            r_ready;

    modport master (
        output aw_addr, aw_len, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_len, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_addr, aw_len, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_len, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/hyperbus_traffic_gen.sv
// Self-checking AXI4 traffic generator: writes num_bursts INCR bursts of an
// incrementing pattern (seed + beat index), reads the same bursts back and
// counts data mismatches and bad responses / last-beat framing errors.
module hyperbus_traffic_gen #(
    parameter int AW    = 32,
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [7:0]           burst_len_i,
    input  logic [CNT_W-1:0]     num_bursts_i,
    input  logic [DW-1:0]        seed_i,
    hyperbus_traffic_gen_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     data_err_cnt_o,
    output logic [CNT_W-1:0]     resp_err_cnt_o,
    output logic [AW-1:0]        first_err_addr_o
);

    localparam int BYTES = DW / 8;

    typedef enum logic [2:0] {IDLE, WA, WD, WB, RA, RD, DONE} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [7:0]       len_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] burst_idx;
    logic [AW-1:0]    base_q;
    logic [AW-1:0]    burst_addr;
    logic [DW-1:0]    seed_q;
    logic [DW-1:0]    pattern;
    logic [7:0]       beat;
    logic             err_seen;

    logic [AW-1:0]    burst_step;
    logic [AW-1:0]    next_addr;
    logic [AW-1:0]    beat_addr;
    logic [CNT_W-1:0] burst_idx_nxt;
    logic             last_burst;
    logic             last_beat;
    logic [1:0]       rd_resp_inc;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign burst_step    = AW'((32'(len_q) + 32'd1) * 32'(BYTES));
    assign next_addr     = burst_addr + burst_step;
    assign beat_addr     = burst_addr + AW'(32'(beat) * 32'(BYTES));
    assign burst_idx_nxt = burst_idx + CNT_W'(1);
    assign last_burst    = (burst_idx_nxt == num_q);
    assign last_beat     = (beat == len_q);
    // A read beat can carry both a bad response and a framing error.
    assign rd_resp_inc   = {1'b0, (bus.r_resp != 2'b00)} + {1'b0, (bus.r_last != last_beat)};

    assign bus.w_strb = '1;
    assign bus.aw_len = len_q;
    assign bus.ar_len = len_q;

    // Transfer sequencer; every bus control and status output is registered here.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state            <= IDLE;
            bus.aw_valid     <= 1'b0;
            bus.w_valid      <= 1'b0;
            bus.b_ready      <= 1'b0;
            bus.ar_valid     <= 1'b0;
            bus.r_ready      <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            data_err_cnt_o   <= '0;
            resp_err_cnt_o   <= '0;
            first_err_addr_o <= '0;
            err_seen         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_q           <= mode_i;
                        len_q            <= burst_len_i;
                        num_q            <= num_bursts_i;
                        base_q           <= base_addr_i;
                        seed_q           <= seed_i;
                        burst_idx        <= '0;
                        beat             <= '0;
                        burst_addr       <= base_addr_i;
                        pattern          <= seed_i;
                        bus.aw_addr      <= base_addr_i;
                        bus.ar_addr      <= base_addr_i;
                        data_err_cnt_o   <= '0;
                        resp_err_cnt_o   <= '0;
                        first_err_addr_o <= '0;
                        err_seen         <= 1'b0;
                        busy_o           <= 1'b1;
                        if (num_bursts_i == '0) begin
                            state <= DONE;
                        end else if (mode_i == 2'b10) begin
                            state        <= RA;
                            bus.ar_valid <= 1'b1;
                        end else begin
                            state        <= WA;
                            bus.aw_valid <= 1'b1;
                        end
                    end
                end
                WA: begin
                    if (bus.aw_ready) begin
                        bus.aw_valid <= 1'b0;
                        bus.w_valid  <= 1'b1;
                        bus.w_data   <= pattern;
                        bus.w_last   <= (len_q == 8'd0);
                        beat         <= '0;
                        state        <= WD;
                    end
                end
                WD: begin
                    if (bus.w_ready) begin
                        pattern <= pattern + DW'(1);
                        if (last_beat) begin
                            bus.w_valid <= 1'b0;
                            bus.w_last  <= 1'b0;
                            bus.b_ready <= 1'b1;
                            state       <= WB;
                        end else begin
                            beat       <= beat + 8'd1;
                            bus.w_data <= pattern + DW'(1);
                            bus.w_last <= (beat + 8'd1 == len_q);
                        end
                    end
                end
                WB: begin
                    if (bus.b_valid) begin
                        bus.b_ready <= 1'b0;
                        if (bus.b_resp != 2'b00) begin
                            resp_err_cnt_o <= sat_add(resp_err_cnt_o, 2'd1);
                        end
                        if (!last_burst) begin
                            burst_idx    <= burst_idx_nxt;
                            burst_addr   <= next_addr;
                            bus.aw_addr  <= next_addr;
                            bus.aw_valid <= 1'b1;
                            state        <= WA;
                        end else if (mode_q == 2'b01) begin
                            state <= DONE;
                        end else begin
                            // Read-back replays the same addresses and pattern.
                            burst_idx    <= '0;
                            burst_addr   <= base_q;
                            bus.ar_addr  <= base_q;
                            pattern      <= seed_q;
                            bus.ar_valid <= 1'b1;
                            state        <= RA;
                        end
                    end
                end
                RA: begin
                    if (bus.ar_ready) begin
                        bus.ar_valid <= 1'b0;
                        bus.r_ready  <= 1'b1;
                        beat         <= '0;
                        state        <= RD;
                    end
                end
                RD: begin
                    if (bus.r_valid) begin
                        pattern <= pattern + DW'(1);
                        if (bus.r_data != pattern) begin
                            data_err_cnt_o <= sat_add(data_err_cnt_o, 2'd1);
                            if (!err_seen) begin
                                first_err_addr_o <= beat_addr;
                                err_seen         <= 1'b1;
                            end
                        end
                        resp_err_cnt_o <= sat_add(resp_err_cnt_o, rd_resp_inc);
                        // Burst length is ours; r_last is only checked, never trusted.
                        if (last_beat) begin
                            bus.r_ready <= 1'b0;
                            if (!last_burst) begin
                                burst_idx    <= burst_idx_nxt;
                                burst_addr   <= next_addr;
                                bus.ar_addr  <= next_addr;
                                bus.ar_valid <= 1'b1;
                                state        <= RA;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hyperbus_traffic_gen.md
Name: hyperbus_traffic_gen

Overview:
Synthesizable, self-checking AXI4 traffic generator for on-chip and FPGA bring-up of the HyperBus controller.
- Issues a programmable number of INCR bursts with a deterministic data pattern, then reads them back and compares.
- Counts data mismatches and non-OKAY responses.
- Sits in place of a CPU/DMA master on the controller's AXI slave port. The downstream adapter ties AxBURST=INCR, AxSIZE=log2(DW/8) and AxID=0.

Parameters:
AW, 32, AXI address width
DW, 16, AXI data width in bits; must be a power of two and at least 8
CNT_W, 16, width of the burst counter and both error counters

Ports:
clk_sys_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse; sampled only in IDLE
mode_i  in  2  00 write-then-read, 01 write-only, 10 read-only, 11 treated as 00
base_addr_i  in  AW  start byte address; must be DW/8-aligned
burst_len_i  in  8  AXI len (beats-1) for every burst
num_bursts_i  in  CNT_W  number of bursts; 0 means no transfer
seed_i  in  DW  pattern seed
aw_addr_o  out  AW  write address
aw_len_o  out  8  write burst length
aw_valid_o  out  1  write address valid
aw_ready_i  in  1  write address ready
w_data_o  out  DW  write data
w_strb_o  out  DW/8  write strobe; always all ones
w_last_o  out  1  last write beat
w_valid_o  out  1  write data valid
w_ready_i  in  1  write data ready
b_resp_i  in  2  write response
b_valid_i  in  1  write response valid
b_ready_o  out  1  write response ready
ar_addr_o  out  AW  read address
ar_len_o  out  8  read burst length
ar_valid_o  out  1  read address valid
ar_ready_i  in  1  read address ready
r_data_i  in  DW  read data
r_resp_i  in  2  read response
r_last_i  in  1  last read beat
r_valid_i  in  1  read data valid
r_ready_o  out  1  read data ready
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse at completion
data_err_cnt_o  out  CNT_W  saturating count of read-data mismatches
resp_err_cnt_o  out  CNT_W  saturating count of bad responses/framing
first_err_addr_o  out  AW  byte address of the first data mismatch

Behaviour:
Reset:
- All valid/ready outputs, busy_o and done_o are 0.
- Both error counters are 0; first_err_addr_o is 0.
- FSM is in IDLE.
- Reset asserted mid-burst abandons the transfer immediately; no completion of the handshake is attempted.

Start and status:
- Counters and first_err_addr_o are cleared on the cycle start_i is accepted, and hold their values after done_o.
- start_i outside IDLE is ignored.
- num_bursts_i==0: IDLE -> DONE; done_o pulses 2 cycles after start_i, with no bus activity.

FSM states: IDLE, WA, WD, WB, RA, RD, DONE.
- IDLE --start--> WA, or RA if mode is read-only.
- Valid rises the cycle after start_i.
- WA: aw_valid_o=1 until aw_valid&aw_ready, then WD.
- WD: w_valid_o=1; the beat advances on w_valid&w_ready; w_last_o=1 on beat burst_len_i; after the last beat, go to WB.
- W is never issued before its AW handshake.
- WB: b_ready_o=1; on b_valid, b_resp!=00 increments resp_err_cnt.
  - More bursts remaining -> WA.
  - Else RA for write-then-read mode, DONE for write-only.
- RA: ar_valid_o=1 until handshake, then RD.
- RD: r_ready_o=1. Each r_valid beat is compared with the expected word.
  - Mismatch increments data_err_cnt. The first mismatch since start latches first_err_addr_o = beat byte address.
  - r_resp!=00 increments resp_err_cnt, once per beat.
  - r_last_i not equal to (beat==burst_len_i) increments resp_err_cnt.
  - The burst ends on beat burst_len_i regardless of r_last_i; then go to RA, or DONE after the final burst.
- DONE: done_o=1 for one cycle, then IDLE.

Handshake rules:
- Valid and payload are held stable until ready.
- Valid is never deasserted without a handshake.

Address and pattern:
- Burst n address = base_addr_i + n*(burst_len_i+1)*(DW/8), modulo 2^AW (wraps silently).
- Data for global beat index k, counted from 0 across all bursts: seed_i + k, modulo 2^DW.
- The read phase restarts k at 0 and reuses the same burst addresses.
- All error counters saturate at 2^CNT_W-1.

Test Plan:
- Defaults, mode 00, base 0x5000, len 15, bursts 2, seed 0xCAFE, zero-wait slave model -> AW addrs 0x5000 then 0x5020; beat 0 data 0xCAFE, beat 31 data 0xCB1D; both error counts 0; done_o single pulse.
- Same as above, with the slave corrupting read beat 5 of burst 1 to 0x0000 -> data_err_cnt=1, first_err_addr=0x502A.
- Mode 01 with the slave returning b_resp=10 on every burst, bursts 3 -> resp_err_cnt=3; no AR ever issued.
- Random ready/valid back-pressure on all five channels, len 99, bursts 1 -> payload stable while valid&!ready; 100 beats; w_last only on beat 99; zero errors.
- Slave asserts r_last on beat 3 of a len-7 read -> resp_err_cnt=2 (early last on beat 3, missing last on beat 7); FSM still reaches DONE.
- rst_i asserted during WD beat 4 -> next cycle all valids=0, busy_o=0; a subsequent start_i completes normally. Also: num_bursts_i=0 -> done_o pulses with no valid ever asserted.
